// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types, constants and helpers for the sequential FP multiplier.
package fp_mul_pkg;
    typedef enum logic [1:0] {IDLE, BOOTH, NORM, DONE} state_e;
    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rmode_e;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [30:0] MAXFIN  = 31'h7F7FFFFF;
    typedef struct packed {
        logic sub;
        logic zero;
        logic inf;
        logic nan;
    } cls_t;
    function automatic cls_t classify(input logic [31:0] f);
        cls_t c;
        c.nan  = f[30:23] == EXP_MAX && f[22:0] != '0;
        c.inf  = f[30:23] == EXP_MAX && f[22:0] == '0;
        c.zero = f[30:23] == '0 && f[22:0] == '0;
        c.sub  = f[30:23] == '0 && f[22:0] != '0;
        return c;
    endfunction
    // Unknown mode encodings fall through to round-to-nearest-even.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign, input logic lsb,
                                       input logic g, input logic s);
        return rm == RTZ ? 1'b0 : rm == RDN ? sign & (g | s) : rm == RUP ? ~sign & (g | s) :
               rm == RMM ? g : g & (s | lsb);
    endfunction
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        return rm == RTZ ? 1'b0 : rm == RDN ? sign : rm == RUP ? ~sign : 1'b1;
    endfunction
endpackage

// File: rtl/booth_r4_sel.sv
// booth_r4_sel: radix-4 Booth digit decode, selecting 0, +-m or +-2m as a signed partial product.
module booth_r4_sel (
    input  logic [2:0]         bits,
    input  logic [23:0]        mcand,
    output logic signed [25:0] pp
);
    logic [25:0] m1, m2;
    assign m1 = {2'b00, mcand};
    assign m2 = {1'b0, mcand, 1'b0};
    assign pp = (bits == 3'b001 || bits == 3'b010) ? m1 :
                bits == 3'b011 ? m2 :
                bits == 3'b100 ? -m2 :
                (bits == 3'b101 || bits == 3'b110) ? -m1 : '0;
endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single multiplier, one radix-4 Booth digit per cycle.
// Optional FP_MUL_SEQ_STICKY_FLAGS_EN adds flag_clr and sticky overflow/underflow outputs.
module fp_mul_seq import fp_mul_pkg::*; #(
    parameter int BOOTH_DIGITS = 13,
    parameter int ACC_W        = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        busy
`ifdef FP_MUL_SEQ_STICKY_FLAGS_EN
   ,input  logic        flag_clr,
    output logic        ovrf_sticky,
    output logic        udrf_sticky
`endif
);
    localparam int YW = 2 * BOOTH_DIGITS + 1;
    localparam int CW = $clog2(BOOTH_DIGITS + 1);

    state_e            state, next;
    logic              accept, special, last, sgn, in_sgn;
    logic [2:0]        rm;
    logic [7:0]        ex, ey;
    logic [23:0]       mx;
    logic [YW-1:0]     y_sh;
    logic [CW-1:0]     cnt;
    logic [ACC_W-1:0]  acc, pp_sh;
    logic signed [25:0] pp;
    cls_t              cx, cy;
    logic [31:0]       spec_z, norm_z;

    assign cx      = classify(fp_X);
    assign cy      = classify(fp_Y);
    assign in_sgn  = fp_X[31] ^ fp_Y[31];
    assign special = |cx || |cy;
    assign spec_z  = (cx.nan || cy.nan || (cx.inf && (cy.zero || cy.sub)) || (cy.inf && (cx.zero || cx.sub))) ? QNAN :
                     (cx.inf || cy.inf) ? {in_sgn, EXP_MAX, 23'b0} : {in_sgn, 31'b0};
    assign last    = cnt == CW'(BOOTH_DIGITS - 1);

    booth_r4_sel u_sel (.bits(y_sh[2:0]), .mcand(mx), .pp(pp));
    assign pp_sh = {{(ACC_W-26){pp[25]}}, pp} << {cnt, 1'b0};

    logic [47:0]       p;
    logic              hi, g, s, inc, ovf, unf;
    logic [22:0]       frac;
    logic [23:0]       rnd;
    logic signed [9:0] e0, e1, e2;
    always_comb begin
        p    = acc[47:0];
        hi   = p[47];
        frac = hi ? p[46:24] : p[45:23];
        g    = hi ? p[23] : p[22];
        s    = hi ? |p[22:0] : |p[21:0];
        e0   = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'(BIAS);
        e1   = e0 + {9'b0, hi};
        inc  = round_inc(rm, sgn, frac[0], g, s);
        rnd  = {1'b0, frac} + {23'b0, inc};
        e2   = e1 + {9'b0, rnd[23]};
        ovf  = e2 >= 10'sd255;
        unf  = e2 <= 10'sd0;
        norm_z = ovf ? (ovf_to_inf(rm, sgn) ? {sgn, EXP_MAX, 23'b0} : {sgn, MAXFIN}) :
                 unf ? {sgn, 31'b0} : {sgn, e2[7:0], rnd[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    always_comb begin
        next      = state;
        in_ready  = rst_n && state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        accept    = in_valid && in_ready;
        case (state)
            IDLE:    next = accept ? (special ? DONE : BOOTH) : IDLE;
            BOOTH:   next = last ? NORM : BOOTH;
            NORM:    next = DONE;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn  <= 1'b0;
            rm   <= '0;
            ex   <= '0;
            ey   <= '0;
            mx   <= '0;
            y_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            fp_Z <= '0;
            ovrf <= 1'b0;
            udrf <= 1'b0;
        end else if (accept) begin
            sgn  <= in_sgn;
            rm   <= r_mode;
            ex   <= fp_X[30:23];
            ey   <= fp_Y[30:23];
            mx   <= {1'b1, fp_X[22:0]};
            y_sh <= {{(YW-25){1'b0}}, 1'b1, fp_Y[22:0], 1'b0};
            acc  <= '0;
            cnt  <= '0;
            if (special) begin
                fp_Z <= spec_z;
                ovrf <= 1'b0;
                udrf <= 1'b0;
            end
        end else if (state == BOOTH) begin
            acc  <= acc + pp_sh;
            y_sh <= y_sh >> 2;
            cnt  <= cnt + 1'b1;
        end else if (state == NORM) begin
            fp_Z <= norm_z;
            ovrf <= ovf;
            udrf <= unf && !ovf;
        end
    end

`ifdef FP_MUL_SEQ_STICKY_FLAGS_EN
    logic hs;
    assign hs = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovrf_sticky <= 1'b0;
            udrf_sticky <= 1'b0;
        end else begin
            ovrf_sticky <= (hs && ovrf) || (ovrf_sticky && !flag_clr);
            udrf_sticky <= (hs && udrf) || (udrf_sticky && !flag_clr);
        end
    end
`endif
endmodule
